// File: rtl/wash_pkg.sv
// Shared types and default pricing for the wash panel controller.
package wash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } wash_state_t;

  localparam int DEF_PRICE        = 2;
  localparam int DEF_DOUBLE_PRICE = 3;
  localparam int CREDIT_W         = 4;

endpackage

// File: rtl/wash_credit_ctr.sv
// Saturating coin credit counter; a rejected coin produces a one-cycle refund pulse.
module wash_credit_ctr
  import wash_pkg::*;
#(
  parameter int MAX_CREDIT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin,
  input  logic                deduct,
  input  logic [CREDIT_W-1:0] cost,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund
);

  logic [CREDIT_W-1:0] credit_reg;
  logic [CREDIT_W-1:0] base_next;
  logic                refund_reg;

  // Deduction is applied first so a coin landing in the same cycle sees the reduced credit.
  always_comb begin
    base_next = credit_reg;
    if (deduct) base_next = credit_reg - cost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_reg <= '0;
      refund_reg <= 1'b0;
    end else begin
      credit_reg <= base_next;
      refund_reg <= 1'b0;
      if (coin) begin
        if (base_next < CREDIT_W'(MAX_CREDIT)) credit_reg <= base_next + 1'b1;
        else                                   refund_reg <= 1'b1;
      end
    end
  end

  assign credit = credit_reg;
  assign refund = refund_reg;

endmodule

// File: rtl/wash_panel_ctrl.sv
// Coin-operated washer front panel: credit, wash selection, start/pause/done sequencing.
// Optional run watchdog enabled by defining WASH_PANEL_TIMEOUT_EN.
module wash_panel_ctrl
  import wash_pkg::*;
#(
  parameter int PRICE        = DEF_PRICE,
  parameter int DOUBLE_PRICE = DEF_DOUBLE_PRICE,
  parameter int MAX_CREDIT   = 9,
  parameter int TIMEOUT      = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_pulse,
  input  logic                double_btn,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic                timer_pause,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund,
  output logic                busy,
  output logic                fault
);

  wash_state_t         state_reg;
  logic                double_sel_reg;
  logic                coin_in_reg;
  logic                timer_pause_reg;
  logic                busy_reg;
  logic [CREDIT_W-1:0] cost;
  logic                fault_blk;

  assign cost = double_sel_reg ? CREDIT_W'(DOUBLE_PRICE) : CREDIT_W'(PRICE);

  wash_credit_ctr #(
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit (
    .clk    (clk),
    .rst    (rst),
    .coin   (coin_pulse),
    .deduct (state_reg == ST_START),
    .cost   (cost),
    .credit (credit),
    .refund (refund)
  );

`ifdef WASH_PANEL_TIMEOUT_EN
  logic        fault_reg;
  logic [31:0] run_cnt_reg;
  assign fault_blk = fault_reg;
  assign fault     = fault_reg;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign fault_blk      = 1'b0;
  assign fault          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      double_sel_reg  <= 1'b0;
      coin_in_reg     <= 1'b0;
      timer_pause_reg <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef WASH_PANEL_TIMEOUT_EN
      fault_reg       <= 1'b0;
      run_cnt_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (double_btn) double_sel_reg <= ~double_sel_reg;
          if (start_btn && !fault_blk && (credit >= cost)) begin
            state_reg <= ST_START;
            busy_reg  <= 1'b1;
          end
        end
        ST_START: begin
          state_reg   <= ST_RUN;
          coin_in_reg <= 1'b1;
`ifdef WASH_PANEL_TIMEOUT_EN
          run_cnt_reg <= '0;
`endif
        end
        ST_RUN: begin
          if (wash_done) begin
            state_reg       <= ST_DONE;
            coin_in_reg     <= 1'b0;
            timer_pause_reg <= 1'b0;
          end
`ifdef WASH_PANEL_TIMEOUT_EN
          // Paused time does not count toward the watchdog.
          else if (!timer_pause_reg && (run_cnt_reg == 32'(TIMEOUT - 1))) begin
            state_reg       <= ST_IDLE;
            coin_in_reg     <= 1'b0;
            timer_pause_reg <= 1'b0;
            busy_reg        <= 1'b0;
            fault_reg       <= 1'b1;
          end
`endif
          else begin
            if (pause_btn) timer_pause_reg <= ~timer_pause_reg;
`ifdef WASH_PANEL_TIMEOUT_EN
            if (!timer_pause_reg) run_cnt_reg <= run_cnt_reg + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          // Wait for done to drop so a held level cannot re-trigger a wash.
          if (!wash_done) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign coin_in     = coin_in_reg;
  assign double_wash = double_sel_reg;
  assign timer_pause = timer_pause_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Scoreboard bench for wash_panel_ctrl: stimulus queues expected outputs, monitor compares at negedge.
module tb_wash_panel_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_pulse = 1'b0, double_btn = 1'b0, start_btn = 1'b0;
  logic       pause_btn = 1'b0, wash_done = 1'b0;
  logic       coin_in, double_wash, timer_pause, refund, busy, fault;
  logic [3:0] credit;

  always #5 clk = ~clk;

  wash_panel_ctrl #(
    .PRICE(2), .DOUBLE_PRICE(3), .MAX_CREDIT(9), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .coin_pulse(coin_pulse), .double_btn(double_btn),
    .start_btn(start_btn), .pause_btn(pause_btn), .wash_done(wash_done),
    .coin_in(coin_in), .double_wash(double_wash), .timer_pause(timer_pause),
    .credit(credit), .refund(refund), .busy(busy), .fault(fault)
  );

  typedef struct {
    string      name;
    logic       ci, dw, tp;
    logic [3:0] cr;
    logic       rf, by, ft;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_fault = 1'b0;

  task automatic chk(input string name, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, exp);
    end
  endtask

  // Monitor: one expectation is consumed per cycle, sampled at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        $display("txn %-12s coin_in=%0b dw=%0b tp=%0b credit=%0d refund=%0b busy=%0b fault=%0b",
                 e.name, coin_in, double_wash, timer_pause, credit, refund, busy, fault);
        chk(e.name, "coin_in", int'(coin_in), int'(e.ci));
        chk(e.name, "double_wash", int'(double_wash), int'(e.dw));
        chk(e.name, "timer_pause", int'(timer_pause), int'(e.tp));
        chk(e.name, "credit", int'(credit), int'(e.cr));
        chk(e.name, "refund", int'(refund), int'(e.rf));
        chk(e.name, "busy", int'(busy), int'(e.by));
        chk(e.name, "fault", int'(fault), int'(e.ft));
      end
    end
  end

  // Drive one cycle of inputs, then queue the outputs expected after that edge.
  task automatic step(input logic c, d, s, p, w, input string name,
                      input logic ci, dw, tp, input int cr, input logic rf, by);
    exp_t e;
    coin_pulse = c; double_btn = d; start_btn = s; pause_btn = p; wash_done = w;
    @(posedge clk);
    #1;
    e.name = name; e.ci = ci; e.dw = dw; e.tp = tp; e.cr = 4'(cr);
    e.rf = rf; e.by = by; e.ft = exp_fault;
    q.push_back(e);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(0,0,0,0,0, "reset",      0,0,0, 0,0,0);
    rst = 1'b0;
    step(0,0,1,0,0, "start_nocr", 0,0,0, 0,0,0);
    // Three coins, single wash
    step(1,0,0,0,0, "coin1",      0,0,0, 1,0,0);
    step(1,0,0,0,0, "coin2",      0,0,0, 2,0,0);
    step(1,0,0,0,0, "coin3",      0,0,0, 3,0,0);
    step(0,0,1,0,0, "start",      0,0,0, 3,0,1);
    step(0,0,0,0,0, "run",        1,0,0, 1,0,1);
    step(0,0,0,0,0, "run_wait",   1,0,0, 1,0,1);
    // Pause toggling, then done handshake
    step(0,0,0,1,0, "pause_on",   1,0,1, 1,0,1);
    step(0,0,0,1,0, "pause_off",  1,0,0, 1,0,1);
    step(0,0,0,1,0, "pause_on2",  1,0,1, 1,0,1);
    step(0,0,0,0,1, "done",       0,0,0, 1,0,1);
    step(0,0,0,0,1, "done_held",  0,0,0, 1,0,1);
    step(0,0,0,0,0, "idle",       0,0,0, 1,0,0);
    // Double wash: insufficient credit then enough
    step(1,0,0,0,0, "coin_keep",  0,0,0, 2,0,0);
    step(0,1,0,0,0, "dbl_sel",    0,1,0, 2,0,0);
    step(0,0,1,0,0, "dbl_nostart",0,1,0, 2,0,0);
    step(1,0,0,0,0, "dbl_coin",   0,1,0, 3,0,0);
    step(0,0,1,0,0, "dbl_start",  0,1,0, 3,0,1);
    step(0,0,0,0,0, "dbl_run",    1,1,0, 0,0,1);
    step(0,1,0,0,0, "dbl_frozen", 1,1,0, 0,0,1);
    step(0,0,0,0,1, "dbl_done",   0,1,0, 0,0,1);
    step(0,0,0,0,0, "dbl_idle",   0,1,0, 0,0,0);
    step(0,1,0,0,0, "dbl_clear",  0,0,0, 0,0,0);
    // Coin arriving in the deduction cycle
    step(1,0,0,0,0, "c1",         0,0,0, 1,0,0);
    step(1,0,0,0,0, "c2",         0,0,0, 2,0,0);
    step(1,0,0,0,0, "c3",         0,0,0, 3,0,0);
    step(0,0,1,0,0, "start_b",    0,0,0, 3,0,1);
    step(1,0,0,0,0, "coin_deduct",1,0,0, 2,0,1);
    step(1,0,0,0,0, "coin_run",   1,0,0, 3,0,1);
    // Reset mid-wash
    rst = 1'b1;
    step(0,0,0,0,0, "rst_run",    0,0,0, 0,0,0);
    rst = 1'b0;
    // Saturation and refund
    for (int i = 1; i <= 9; i++)
      step(1,0,0,0,0, $sformatf("sat%0d", i), 0,0,0, i,0,0);
    step(1,0,0,0,0, "refund",     0,0,0, 9,1,0);
    step(0,0,0,0,0, "refund_end", 0,0,0, 9,0,0);
    step(0,0,1,0,0, "start_full", 0,0,0, 9,0,1);
    step(1,0,0,0,0, "full_deduct",1,0,0, 8,0,1);
    step(0,0,0,0,1, "full_done",  0,0,0, 8,0,1);
    step(0,0,0,0,0, "full_idle",  0,0,0, 8,0,0);
`ifdef WASH_PANEL_TIMEOUT_EN
    // Watchdog: 20 unpaused RUN cycles without done
    step(0,0,1,0,0, "to_start",   0,0,0, 8,0,1);
    step(0,0,0,0,0, "to_run",     1,0,0, 6,0,1);
    for (int i = 1; i < 20; i++)
      step(0,0,0,0,0, $sformatf("to_wait%0d", i), 1,0,0, 6,0,1);
    exp_fault = 1'b1;
    step(0,0,0,0,0, "to_fault",   0,0,0, 6,0,0);
    step(0,0,1,0,0, "to_blocked", 0,0,0, 6,0,0);
    step(0,0,0,0,0, "to_sticky",  0,0,0, 6,0,0);
    rst = 1'b1;
    exp_fault = 1'b0;
    step(0,0,0,0,0, "to_clear",   0,0,0, 0,0,0);
    rst = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_panel_ctrl.md
WASH_PANEL_CTRL -- requirements
Module: wash_panel_ctrl

Interface
REQ-001 Parameter PRICE, default 2: coins for a single wash.
REQ-002 Parameter DOUBLE_PRICE, default 3: coins for a double wash.
REQ-003 Parameter MAX_CREDIT, default 9: credit saturation limit.
REQ-004 Parameter TIMEOUT, default 1000: watchdog limit in cycles, used only under the Configuration macro.
REQ-005 clk  in  1: single clock, rising-edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 coin_pulse  in  1: one-cycle pulse per user coin.
REQ-008 double_btn  in  1: one-cycle pulse toggling double-wash selection.
REQ-009 start_btn  in  1: one-cycle pulse requesting a wash.
REQ-010 pause_btn  in  1: one-cycle pulse toggling pause during a wash.
REQ-011 wash_done  in  1: washer completion, level, sampled each cycle.
REQ-012 coin_in  out  1: level to washer; a wash is requested while high.
REQ-013 double_wash  out  1: level to washer; double-wash selection.
REQ-014 timer_pause  out  1: level to washer; freezes washer timer.
REQ-015 credit  out  4: current coin credit.
REQ-016 refund  out  1: one-cycle pulse returning a coin that was not accepted.
REQ-017 busy  out  1: high in states START, RUN and DONE.
REQ-018 fault  out  1: sticky watchdog fault; present only under the macro.

Function
REQ-019 FSM states: IDLE, START, RUN, DONE; registered outputs only.
REQ-020 coin_pulse in any state: credit+1 if credit<MAX_CREDIT, else refund=1 next cycle and credit unchanged.
REQ-021 double_btn in IDLE toggles double_sel; ignored in all other states; double_wash=double_sel.
REQ-022 cost = double_sel ? DOUBLE_PRICE : PRICE.
REQ-023 IDLE->START on start_btn when credit>=cost; start_btn with insufficient credit is ignored.
REQ-024 START lasts one cycle: credit -= cost; coin_in goes high on entry to RUN.
REQ-025 Coin and deduction in the same cycle: credit = credit - cost + 1, subject to MAX_CREDIT saturation.
REQ-026 RUN: coin_in=1, double_wash frozen; pause_btn toggles timer_pause.
REQ-027 RUN->DONE when wash_done=1 is sampled; coin_in=0 and timer_pause=0 on entry to DONE.
REQ-028 DONE->IDLE once wash_done=0, which prevents re-triggering on a held done level.
REQ-029 Remaining credit is retained across washes.

Reset
REQ-030 On rst: state=IDLE, credit=0, double_sel=0, coin_in=0, double_wash=0, timer_pause=0, refund=0, busy=0, fault=0.
REQ-031 rst mid-wash aborts the wash immediately; the deducted credit is lost.

Configuration
REQ-032 Macro WASH_PANEL_TIMEOUT_EN: when defined, a cycle counter runs in RUN and freezes while timer_pause=1.
REQ-033 With WASH_PANEL_TIMEOUT_EN, reaching TIMEOUT in RUN -> IDLE, coin_in=0 and fault=1 until rst; start_btn is ignored while fault=1.
REQ-034 Without WASH_PANEL_TIMEOUT_EN: no counter, fault tied to 0, RUN waits indefinitely.

Structure
REQ-035 Package wash_pkg holds the FSM state enum and the default PRICE/DOUBLE_PRICE constants.
REQ-036 Sub-module wash_credit_ctr implements the saturating credit counter and refund generation.

Verification
REQ-037 Three coin pulses, start_btn -> START one cycle later, credit=1, coin_in=1, double_wash=0.
REQ-038 credit=2, double_btn, start_btn -> no start, credit stays 2; one more coin and start_btn -> double_wash=1, credit=0.
REQ-039 RUN, pause_btn twice -> timer_pause 1 then 0; wash_done=1 -> coin_in=0 next cycle, then IDLE after wash_done=0.
REQ-040 credit=9, coin_pulse -> refund=1 for one cycle, credit=9.
REQ-041 rst during RUN -> next cycle: coin_in=0, credit=0, busy=0.
REQ-042 With WASH_PANEL_TIMEOUT_EN and TIMEOUT=20, no wash_done -> fault=1 at cycle 20 of RUN, coin_in=0, later start_btn ignored.
